// File: rtl/can_pkg.sv
// can_pkg: definitions shared by the CAN receive path. The future transmitter
// will use them too.
//   - can_state_e  : frame decoder state encoding
//   - LEN_*        : fixed field lengths in (de-stuffed) bits
//   - CRC_POLY     : CRC-15 generator polynomial
//   - ERR_*        : err_code values reported by the decoder
//   - crc15_step() : one serial CRC-15 update
package can_pkg;

  typedef enum logic [4:0] {
    ST_INTEGRATE,
    ST_IDLE,
    ST_ID_A,
    ST_SRR_RTR,
    ST_IDE,
    ST_ID_B,
    ST_RTR,
    ST_R1,
    ST_R0,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_INTERMISSION
  } can_state_e;

  localparam int LEN_ID_A         = 11;
  localparam int LEN_ID_B         = 18;
  localparam int LEN_DLC          = 4;
  localparam int LEN_CRC          = 15;
  localparam int LEN_EOF          = 7;
  localparam int LEN_INTERMISSION = 3;

  localparam logic [14:0] CRC_POLY = 15'h4599;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_STUFF = 3'd1;
  localparam logic [2:0] ERR_CRC   = 3'd2;
  localparam logic [2:0] ERR_FORM  = 3'd3;

  // Shift one bit into the CRC-15 register (MSB-first polynomial division).
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic din);
    logic nxt;
    nxt = din ^ crc[14];
    return {crc[13:0], 1'b0} ^ (nxt ? CRC_POLY : 15'd0);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// can_crc15: serial CAN CRC-15 generator/checker.
// Ports:
//   clkin  in   bit clock
//   rstn   in   asynchronous active-low reset (register -> 0)
//   clear  in   restart from 0; when combined with en, the bit is shifted into the cleared value
//   en     in   shift din into the register this cycle
//   din    in   serial bit
//   crc    out  current 15-bit register value
module can_crc15
  import can_pkg::*;
(
  input  logic        clkin,
  input  logic        rstn,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [14:0] crc
);

  logic [14:0] crc_reg;
  logic [14:0] crc_next;
  logic [14:0] crc_base;

  always_comb begin
    crc_base = clear ? 15'd0 : crc_reg;
    crc_next = crc_base;
    if (en) begin
      crc_next = crc15_step(crc_base, din);
    end
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      crc_reg <= 15'd0;
    end else begin
      crc_reg <= crc_next;
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/can_frame_decoder.sv
// can_frame_decoder: CAN frame receiver that sits after the bit unstuffer.
// It decodes base and extended data/remote frames from the de-stuffed stream
// and checks the CRC, the fixed-form fields and the unstuffer's stuff errors.
// It only receives and never drives ACK.
// Ports:
//   clkin        in   bit clock, shared with the unstuffer
//   rstn         in   asynchronous active-low reset
//   rx           in   de-stuffed bit, 1 = recessive
//   bit_en       in   1 = rx is a real bit, 0 = stuffed slot (nothing changes)
//   stuff_err    in   unstuffer error, only honoured while stuff_en=1
//   stuff_en     out  enable to the unstuffer (from the bit after SOF through the last CRC bit)
//   frame_valid  out  one-cycle pulse when a frame is accepted
//   id/ide/rtr/dlc/data/ack_seen  out  fields of the last accepted frame
//   err_pulse    out  one-cycle pulse on any error
//   err_code     out  0 none, 1 stuff, 2 crc, 3 form
module can_frame_decoder
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11,
  parameter int MAX_BYTES = 8
) (
  input  logic        clkin,
  input  logic        rstn,
  input  logic        rx,
  input  logic        bit_en,
  input  logic        stuff_err,
  output logic        stuff_en,
  output logic        frame_valid,
  output logic [28:0] id,
  output logic        ide,
  output logic        rtr,
  output logic [3:0]  dlc,
  output logic [63:0] data,
  output logic        ack_seen,
  output logic        err_pulse,
  output logic [2:0]  err_code
);

  localparam logic [6:0] LAST_IDLE  = 7'(IDLE_BITS - 1);
  localparam logic [6:0] LAST_ID_A  = 7'(LEN_ID_A - 1);
  localparam logic [6:0] LAST_ID_B  = 7'(LEN_ID_B - 1);
  localparam logic [6:0] LAST_DLC   = 7'(LEN_DLC - 1);
  localparam logic [6:0] LAST_CRC   = 7'(LEN_CRC - 1);
  localparam logic [6:0] LAST_EOF   = 7'(LEN_EOF - 1);
  localparam logic [6:0] LAST_INTER = 7'(LEN_INTERMISSION - 1);

  // Data bytes actually carried by the frame: remote frames carry none and
  // a DLC above MAX_BYTES still carries only MAX_BYTES.
  function automatic logic [3:0] calc_nbytes(input logic [3:0] d, input logic r);
    if (r) return 4'd0;
    if (int'(d) > MAX_BYTES) return 4'(MAX_BYTES);
    return d;
  endfunction

  can_state_e  state_reg, state_next;
  // Counts up from 0 within each field and is reloaded to 0 whenever the state changes.
  logic [6:0]  cnt_reg, cnt_next;
  logic        stuff_en_reg, stuff_en_next;

  // Fields of the frame being received.
  logic [28:0] id_work_reg, id_work_next;
  logic        ide_work_reg, ide_work_next;
  logic        rtr_work_reg, rtr_work_next;
  logic [3:0]  dlc_work_reg, dlc_work_next;
  logic [63:0] data_work_reg, data_work_next;
  logic        ack_work_reg, ack_work_next;
  logic [14:0] crc_rx_reg, crc_rx_next;

  // Output registers.
  logic        frame_valid_reg, frame_valid_next;
  logic [28:0] id_reg, id_next;
  logic        ide_reg, ide_next;
  logic        rtr_reg, rtr_next;
  logic [3:0]  dlc_reg, dlc_next;
  logic [63:0] data_reg, data_next;
  logic        ack_seen_reg, ack_seen_next;
  logic        err_pulse_reg, err_pulse_next;
  logic [2:0]  err_code_reg, err_code_next;

  logic        crc_clr, crc_en;
  logic [14:0] crc_val;
  logic        form_err, crc_err, serr, accept;
  logic [3:0]  dlc_full;
  logic [3:0]  nbytes;
  logic [6:0]  data_last;
  logic [5:0]  data_idx;

  can_crc15 u_crc (
    .clkin (clkin),
    .rstn  (rstn),
    .clear (crc_clr),
    .en    (crc_en),
    .din   (rx),
    .crc   (crc_val)
  );

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    stuff_en_next    = stuff_en_reg;
    id_work_next     = id_work_reg;
    ide_work_next    = ide_work_reg;
    rtr_work_next    = rtr_work_reg;
    dlc_work_next    = dlc_work_reg;
    data_work_next   = data_work_reg;
    ack_work_next    = ack_work_reg;
    crc_rx_next      = crc_rx_reg;
    frame_valid_next = 1'b0;
    id_next          = id_reg;
    ide_next         = ide_reg;
    rtr_next         = rtr_reg;
    dlc_next         = dlc_reg;
    data_next        = data_reg;
    ack_seen_next    = ack_seen_reg;
    err_pulse_next   = 1'b0;
    err_code_next    = err_code_reg;
    crc_clr          = 1'b0;
    crc_en           = 1'b0;
    form_err         = 1'b0;
    crc_err          = 1'b0;
    serr             = 1'b0;
    accept           = 1'b0;
    // Complete DLC value once its last bit is on rx.
    dlc_full         = {dlc_work_reg[2:0], rx};
    nbytes           = calc_nbytes(dlc_work_reg, rtr_work_reg);
    data_last        = {nbytes, 3'b000} - 7'd1;
    // Byte 0 lands in data[63:56]: bit k of the DATA field goes to data[63-k].
    data_idx         = 6'(7'd63 - cnt_reg);

    if (bit_en) begin
      cnt_next = cnt_reg + 7'd1;
      unique case (state_reg)
        ST_INTEGRATE: begin
          if (!rx) begin
            cnt_next = 7'd0;
          end else if (cnt_reg == LAST_IDLE) begin
            state_next = ST_IDLE;
            cnt_next   = 7'd0;
          end
        end
        ST_IDLE: begin
          cnt_next = 7'd0;
          if (!rx) begin
            crc_clr        = 1'b1;
            crc_en         = 1'b1;
            id_work_next   = '0;
            ide_work_next  = 1'b0;
            rtr_work_next  = 1'b0;
            dlc_work_next  = '0;
            data_work_next = '0;
            ack_work_next  = 1'b0;
            crc_rx_next    = '0;
            err_code_next  = ERR_NONE;
            stuff_en_next  = 1'b1;
            state_next     = ST_ID_A;
          end
        end
        ST_ID_A: begin
          crc_en       = 1'b1;
          id_work_next = {id_work_reg[27:0], rx};
          if (cnt_reg == LAST_ID_A) begin
            state_next = ST_SRR_RTR;
            cnt_next   = 7'd0;
          end
        end
        ST_SRR_RTR: begin
          // RTR for base frames, SRR for extended frames (overwritten in ST_RTR).
          crc_en        = 1'b1;
          rtr_work_next = rx;
          state_next    = ST_IDE;
          cnt_next      = 7'd0;
        end
        ST_IDE: begin
          crc_en        = 1'b1;
          ide_work_next = rx;
          state_next    = rx ? ST_ID_B : ST_R0;
          cnt_next      = 7'd0;
        end
        ST_ID_B: begin
          crc_en       = 1'b1;
          id_work_next = {id_work_reg[27:0], rx};
          if (cnt_reg == LAST_ID_B) begin
            state_next = ST_RTR;
            cnt_next   = 7'd0;
          end
        end
        ST_RTR: begin
          crc_en        = 1'b1;
          rtr_work_next = rx;
          state_next    = ST_R1;
          cnt_next      = 7'd0;
        end
        ST_R1: begin
          crc_en     = 1'b1;
          state_next = ST_R0;
          cnt_next   = 7'd0;
        end
        ST_R0: begin
          crc_en     = 1'b1;
          state_next = ST_DLC;
          cnt_next   = 7'd0;
        end
        ST_DLC: begin
          crc_en        = 1'b1;
          dlc_work_next = dlc_full;
          if (cnt_reg == LAST_DLC) begin
            state_next = (calc_nbytes(dlc_full, rtr_work_reg) == 4'd0) ? ST_CRC : ST_DATA;
            cnt_next   = 7'd0;
          end
        end
        ST_DATA: begin
          crc_en                   = 1'b1;
          data_work_next[data_idx] = rx;
          if (cnt_reg == data_last) begin
            state_next = ST_CRC;
            cnt_next   = 7'd0;
          end
        end
        ST_CRC: begin
          crc_rx_next = {crc_rx_reg[13:0], rx};
          if (cnt_reg == LAST_CRC) begin
            stuff_en_next = 1'b0;
            state_next    = ST_CRC_DEL;
            cnt_next      = 7'd0;
          end
        end
        ST_CRC_DEL: begin
          form_err   = !rx;
          crc_err    = (crc_rx_reg != crc_val);
          state_next = ST_ACK_SLOT;
          cnt_next   = 7'd0;
        end
        ST_ACK_SLOT: begin
          ack_work_next = !rx;
          state_next    = ST_ACK_DEL;
          cnt_next      = 7'd0;
        end
        ST_ACK_DEL: begin
          form_err   = !rx;
          state_next = ST_EOF;
          cnt_next   = 7'd0;
        end
        ST_EOF: begin
          form_err = !rx;
          if (cnt_reg == LAST_EOF) begin
            accept     = 1'b1;
            state_next = ST_INTERMISSION;
            cnt_next   = 7'd0;
          end
        end
        ST_INTERMISSION: begin
          if (cnt_reg == LAST_INTER) begin
            state_next = ST_IDLE;
            cnt_next   = 7'd0;
          end
        end
        default: begin
          state_next = ST_INTEGRATE;
          cnt_next   = 7'd0;
        end
      endcase

      serr = stuff_en_reg && stuff_err;

      if (serr || form_err || crc_err) begin
        err_pulse_next = 1'b1;
        err_code_next  = serr ? ERR_STUFF : (form_err ? ERR_FORM : ERR_CRC);
        stuff_en_next  = 1'b0;
        state_next     = ST_INTEGRATE;
        cnt_next       = 7'd0;
      end else if (accept) begin
        frame_valid_next = 1'b1;
        id_next          = id_work_reg;
        ide_next         = ide_work_reg;
        rtr_next         = rtr_work_reg;
        dlc_next         = dlc_work_reg;
        data_next        = data_work_reg;
        ack_seen_next    = ack_work_reg;
      end
    end
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= ST_INTEGRATE;
      cnt_reg         <= '0;
      stuff_en_reg    <= 1'b0;
      id_work_reg     <= '0;
      ide_work_reg    <= 1'b0;
      rtr_work_reg    <= 1'b0;
      dlc_work_reg    <= '0;
      data_work_reg   <= '0;
      ack_work_reg    <= 1'b0;
      crc_rx_reg      <= '0;
      frame_valid_reg <= 1'b0;
      id_reg          <= '0;
      ide_reg         <= 1'b0;
      rtr_reg         <= 1'b0;
      dlc_reg         <= '0;
      data_reg        <= '0;
      ack_seen_reg    <= 1'b0;
      err_pulse_reg   <= 1'b0;
      err_code_reg    <= ERR_NONE;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      stuff_en_reg    <= stuff_en_next;
      id_work_reg     <= id_work_next;
      ide_work_reg    <= ide_work_next;
      rtr_work_reg    <= rtr_work_next;
      dlc_work_reg    <= dlc_work_next;
      data_work_reg   <= data_work_next;
      ack_work_reg    <= ack_work_next;
      crc_rx_reg      <= crc_rx_next;
      frame_valid_reg <= frame_valid_next;
      id_reg          <= id_next;
      ide_reg         <= ide_next;
      rtr_reg         <= rtr_next;
      dlc_reg         <= dlc_next;
      data_reg        <= data_next;
      ack_seen_reg    <= ack_seen_next;
      err_pulse_reg   <= err_pulse_next;
      err_code_reg    <= err_code_next;
    end
  end

  assign stuff_en    = stuff_en_reg;
  assign frame_valid = frame_valid_reg;
  assign id          = id_reg;
  assign ide         = ide_reg;
  assign rtr         = rtr_reg;
  assign dlc         = dlc_reg;
  assign data        = data_reg;
  assign ack_seen    = ack_seen_reg;
  assign err_pulse   = err_pulse_reg;
  assign err_code    = err_code_reg;

endmodule

// File: tb/tb_can_frame_decoder.sv
// tb_can_frame_decoder: self-checking bench for can_frame_decoder.
// Frames are built as de-stuffed bit streams together with their CRC. A vector
// table covers the good frames, and directed sequences cover the error cases,
// the integration boundary and reset.
module tb_can_frame_decoder;

  logic        clkin = 1'b0;
  logic        rstn;
  logic        rx;
  logic        bit_en;
  logic        stuff_err;
  logic        stuff_en;
  logic        frame_valid;
  logic [28:0] id;
  logic        ide;
  logic        rtr;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic        ack_seen;
  logic        err_pulse;
  logic [2:0]  err_code;

  can_frame_decoder #(.IDLE_BITS(11), .MAX_BYTES(8)) dut (
    .clkin       (clkin),
    .rstn        (rstn),
    .rx          (rx),
    .bit_en      (bit_en),
    .stuff_err   (stuff_err),
    .stuff_en    (stuff_en),
    .frame_valid (frame_valid),
    .id          (id),
    .ide         (ide),
    .rtr         (rtr),
    .dlc         (dlc),
    .data        (data),
    .ack_seen    (ack_seen),
    .err_pulse   (err_pulse),
    .err_code    (err_code)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_errors = 0;

  // Frame under construction.
  logic fb [0:255];
  int   fb_len;
  int   idx_data0, idx_crc_last, idx_crc_del, idx_ack_del, idx_eof0;

  // Observations gathered while bits are sent.
  int          cur_idx;
  int          fv_count, err_count, err_idx, se_bad;
  logic [2:0]  err_code_at;
  logic        stuff_en_at_err;
  logic [28:0] cap_id;
  logic        cap_ide, cap_rtr, cap_ack;
  logic [3:0]  cap_dlc;
  logic [63:0] cap_data;

  typedef struct {
    logic [28:0] fid;
    logic        fide;
    logic        frtr;
    logic [3:0]  fdlc;
    logic [63:0] din;
    logic [63:0] dexp;
    logic        gaps;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic n;
    n = b ^ c[14];
    c = {c[13:0], 1'b0};
    if (n) c = c ^ 15'h4599;
    return c;
  endfunction

  task automatic push(input logic b);
    fb[fb_len] = b;
    fb_len++;
  endtask

  task automatic build_frame(input logic [28:0] fid, input logic fide, input logic frtr,
                             input logic [3:0] fdlc, input logic [63:0] fdata);
    logic [14:0] c;
    int nb;
    fb_len = 0;
    push(1'b0);
    if (fide) begin
      for (int k = 28; k >= 18; k--) push(fid[k]);
      push(1'b1);
      push(1'b1);
      for (int k = 17; k >= 0; k--) push(fid[k]);
      push(frtr);
      push(1'b0);
      push(1'b0);
    end else begin
      for (int k = 10; k >= 0; k--) push(fid[k]);
      push(frtr);
      push(1'b0);
      push(1'b0);
    end
    for (int k = 3; k >= 0; k--) push(fdlc[k]);
    nb = frtr ? 0 : ((fdlc > 4'd8) ? 8 : int'(fdlc));
    idx_data0 = fb_len;
    for (int k = 0; k < 8 * nb; k++) push(fdata[63-k]);
    c = 15'd0;
    for (int k = 0; k < fb_len; k++) c = crc_step(c, fb[k]);
    for (int k = 14; k >= 0; k--) push(c[k]);
    idx_crc_last = fb_len - 1;
    idx_crc_del  = fb_len;
    push(1'b1);
    push(1'b0);
    idx_ack_del = fb_len;
    push(1'b1);
    idx_eof0 = fb_len;
    repeat (7) push(1'b1);
    repeat (3) push(1'b1);
  endtask

  task automatic tick(input logic b, input logic en, input logic serr);
    rx        = b;
    bit_en    = en;
    stuff_err = serr;
    @(posedge clkin);
    #1;
    if (frame_valid) begin
      fv_count++;
      cap_id   = id;
      cap_ide  = ide;
      cap_rtr  = rtr;
      cap_dlc  = dlc;
      cap_data = data;
      cap_ack  = ack_seen;
    end
    if (err_pulse) begin
      err_count++;
      if (err_idx < 0) begin
        err_idx         = cur_idx;
        err_code_at     = err_code;
        stuff_en_at_err = stuff_en;
      end
    end
  endtask

  task automatic idle_bits(input int n);
    cur_idx = -1;
    repeat (n) tick(1'b1, 1'b1, 1'b0);
  endtask

  // Send the built frame. flip_idx corrupts one bit, serr_idx raises stuff_err on
  // one bit, rst_idx pulses rstn after that bit, stop_idx truncates (-1 = none).
  task automatic send_frame(input logic gaps, input int serr_idx, input int rst_idx,
                            input int flip_idx, input int stop_idx);
    logic b;
    logic did_rst;
    logic exp_se;
    int   last;
    fv_count  = 0;
    err_count = 0;
    err_idx   = -1;
    se_bad    = 0;
    did_rst   = 1'b0;
    last      = (stop_idx >= 0) ? stop_idx : fb_len - 1;
    for (int i = 0; i <= last; i++) begin
      cur_idx = i;
      b = fb[i] ^ (i == flip_idx);
      if (gaps && (i % 5 == 4)) tick(~b, 1'b0, 1'b1);
      tick(b, 1'b1, (i == serr_idx));
      if (err_idx < 0 && !did_rst) begin
        exp_se = (i < idx_crc_last);
        if (stuff_en !== exp_se) se_bad++;
      end
      if (i == rst_idx) begin
        #2;
        rstn = 1'b0;
        #1;
        check("rst_stuff_en", 64'(stuff_en), 64'd0);
        check("rst_id", 64'(id), 64'd0);
        check("rst_data", data, 64'd0);
        check("rst_flags", {57'd0, frame_valid, err_pulse, ide, rtr, ack_seen, err_code == 3'd0 ? 1'b0 : 1'b1, dlc != 4'd0},
              64'd0);
        @(posedge clkin);
        #1;
        rstn    = 1'b1;
        did_rst = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{29'h123,      1'b0, 1'b0, 4'd2,  64'hABCD_0000_0000_0000, 64'hABCD_0000_0000_0000, 1'b0};
    vecs[1] = '{29'h1ABCDEF0, 1'b1, 1'b1, 4'd4,  64'h1122_3344_0000_0000, 64'h0,                   1'b0};
    vecs[2] = '{29'h2A5,      1'b0, 1'b0, 4'd15, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 1'b0};
    vecs[3] = '{29'h123,      1'b0, 1'b0, 4'd2,  64'hABCD_0000_0000_0000, 64'hABCD_0000_0000_0000, 1'b1};
    vecs[4] = '{29'h15555555, 1'b1, 1'b0, 4'd1,  64'h5A00_0000_0000_0000, 64'h5A00_0000_0000_0000, 1'b1};
    vecs[5] = '{29'h7FF,      1'b0, 1'b0, 4'd0,  64'h0,                   64'h0,                   1'b0};

    rstn      = 1'b0;
    rx        = 1'b1;
    bit_en    = 1'b0;
    stuff_err = 1'b0;
    cur_idx   = -1;
    err_idx   = -1;
    repeat (3) @(posedge clkin);
    #1;
    check("reset_stuff_en", 64'(stuff_en), 64'd0);
    check("reset_pulses", {62'd0, frame_valid, err_pulse}, 64'd0);
    check("reset_err_code", 64'(err_code), 64'd0);
    check("reset_fields", {29'd0, id, ide, rtr, dlc, ack_seen}, 64'd0);
    check("reset_data", data, 64'd0);
    rstn = 1'b1;

    // Good frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      idle_bits(11);
      build_frame(vecs[v].fid, vecs[v].fide, vecs[v].frtr, vecs[v].fdlc, vecs[v].din);
      send_frame(vecs[v].gaps, -1, -1, -1, -1);
      $display("vector %0d: id=%0h ide=%0b rtr=%0b dlc=%0d data=%016h valid=%0d", v,
               cap_id, cap_ide, cap_rtr, cap_dlc, cap_data, fv_count);
      check($sformatf("v%0d_frame_valid", v), 64'(fv_count), 64'd1);
      check($sformatf("v%0d_err_pulses", v), 64'(err_count), 64'd0);
      check($sformatf("v%0d_id", v), 64'(cap_id), 64'(vecs[v].fid));
      check($sformatf("v%0d_ide", v), 64'(cap_ide), 64'(vecs[v].fide));
      check($sformatf("v%0d_rtr", v), 64'(cap_rtr), 64'(vecs[v].frtr));
      check($sformatf("v%0d_dlc", v), 64'(cap_dlc), 64'(vecs[v].fdlc));
      check($sformatf("v%0d_data", v), cap_data, vecs[v].dexp);
      check($sformatf("v%0d_ack_seen", v), 64'(cap_ack), 64'd1);
      check($sformatf("v%0d_stuff_en_window", v), 64'(se_bad), 64'd0);
    end

    // CRC error, truncated just after the dominant ACK slot.
    idle_bits(11);
    build_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000);
    send_frame(1'b0, -1, -1, idx_crc_last - 3, idx_crc_del + 1);
    $display("crc error: err_idx=%0d code=%0d", err_idx, err_code_at);
    check("crc_err_pos", 64'(err_idx), 64'(idx_crc_del));
    check("crc_err_code", 64'(err_code_at), 64'd2);
    check("crc_err_count", 64'(err_count), 64'd1);
    check("crc_no_valid", 64'(fv_count), 64'd0);
    check("crc_err_code_hold", 64'(err_code), 64'd2);
    // Only 10 recessive bits: still integrating, frame ignored.
    idle_bits(10);
    send_frame(1'b0, -1, -1, -1, -1);
    $display("after 10 idle bits: valid=%0d", fv_count);
    check("integ10_no_valid", 64'(fv_count), 64'd0);
    check("integ10_no_err", 64'(err_count), 64'd0);
    idle_bits(11);
    send_frame(1'b0, -1, -1, -1, -1);
    $display("after 11 idle bits: valid=%0d id=%0h", fv_count, cap_id);
    check("integ11_valid", 64'(fv_count), 64'd1);
    check("integ11_id", 64'(cap_id), 64'h123);

    // Stuff error in the DATA field.
    idle_bits(11);
    build_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000);
    send_frame(1'b0, idx_data0 + 3, -1, -1, -1);
    $display("stuff error: err_idx=%0d code=%0d stuff_en=%0b", err_idx, err_code_at, stuff_en_at_err);
    check("stuff_err_pos", 64'(err_idx), 64'(idx_data0 + 3));
    check("stuff_err_code", 64'(err_code_at), 64'd1);
    check("stuff_err_stuff_en", 64'(stuff_en_at_err), 64'd0);
    check("stuff_err_no_valid", 64'(fv_count), 64'd0);

    // Dominant ACK delimiter.
    idle_bits(11);
    send_frame(1'b0, -1, -1, idx_ack_del, -1);
    $display("ack_del error: err_idx=%0d code=%0d", err_idx, err_code_at);
    check("ackdel_err_pos", 64'(err_idx), 64'(idx_ack_del));
    check("ackdel_err_code", 64'(err_code_at), 64'd3);
    check("ackdel_no_valid", 64'(fv_count), 64'd0);

    // Dominant 4th EOF bit.
    idle_bits(11);
    send_frame(1'b0, -1, -1, idx_eof0 + 3, -1);
    $display("eof error: err_idx=%0d code=%0d", err_idx, err_code_at);
    check("eof_err_pos", 64'(err_idx), 64'(idx_eof0 + 3));
    check("eof_err_code", 64'(err_code_at), 64'd3);
    check("eof_no_valid", 64'(fv_count), 64'd0);

    // Reset in the middle of DATA, then recovery.
    idle_bits(11);
    build_frame(29'h123, 1'b0, 1'b0, 4'd8, 64'h0102_0304_0506_0708);
    send_frame(1'b0, -1, idx_data0 + 20, -1, -1);
    $display("reset mid-data: valid=%0d err=%0d", fv_count, err_count);
    check("rst_no_valid", 64'(fv_count), 64'd0);
    check("rst_no_err", 64'(err_count), 64'd0);
    idle_bits(11);
    send_frame(1'b0, -1, -1, -1, -1);
    $display("after reset: valid=%0d data=%016h", fv_count, cap_data);
    check("rst_recover_valid", 64'(fv_count), 64'd1);
    check("rst_recover_data", cap_data, 64'h0102_0304_0506_0708);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
